// File: rtl/lab61soc_pio_pkg.sv
// Shared constants for the lab61soc button/switch PIO: register addresses,
// edge-type codes and the edge-match helper used by the capture logic.
package lab61soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // True when a committed change of the clean bit matches the capture type.
    // old_db is the clean value before the commit, so the new value is ~old_db.
    function automatic logic edge_match(input int edge_type, input logic commit,
                                        input logic old_db);
        logic hit;
        case (edge_type)
            EDGE_RISE: hit = commit & ~old_db;
            EDGE_FALL: hit = commit & old_db;
            default:   hit = commit;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/lab61soc_pio_debounce.sv
// One input bit: two-flop synchroniser followed by the clean register db.
// With PIO_DEBOUNCE_EN defined a stability counter gates every change of db;
// otherwise db simply follows the synchroniser output one cycle later.
// commit is high during the cycle whose closing edge changes db.
module lab61soc_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic db,
    output logic commit
);

    logic s1_reg;
    logic s2_reg;
    logic db_reg;

    // Metastability guard for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign commit = (s2_reg != db_reg) && (cnt_reg == CNT_LAST);

    // Accept a new level only after it has differed from db for
    // DEBOUNCE_CYCLES consecutive edges; any return to db restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            db_reg  <= 1'b0;
        end else if (s2_reg == db_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            db_reg  <= s2_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
`else
    // The stability threshold has no meaning without counters.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign commit = (s2_reg != db_reg);

    // Clean value tracks the synchroniser with one extra register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_reg <= 1'b0;
        end else begin
            db_reg <= s2_reg;
        end
    end
`endif

    assign db = db_reg;

endmodule

// File: rtl/lab61soc_btn_pio.sv
// Avalon-MM input PIO for the lab61soc push buttons and switches.
// Registers: DATA (clean value), IRQMASK, EDGECAP (write-1-to-clear) and a
// level interrupt. Build option PIO_DEBOUNCE_EN enables per-bit debouncing.
module lab61soc_btn_pio
    import lab61soc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] clear_mask;
    logic [31:0]      readdata_reg;
    logic [31:0]      read_mux;
    logic             irq_reg;
    logic             wr_en;
    logic             unused_writedata;

    // Upper writedata bits beyond WIDTH carry no meaning for this peripheral.
    assign unused_writedata = &{1'b0, writedata};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            lab61soc_pio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .din    (in_port[gi]),
                .db     (db[gi]),
                .commit (commit[gi])
            );
            assign edge_hit[gi] = edge_match(EDGE_TYPE, commit[gi], db[gi]);
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    // Capture bits set on a matching commit; a same-edge clear loses to the set.
    always_comb begin
        clear_mask = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            clear_mask = writedata[WIDTH-1:0];
        end
        edgecap_next = (edgecap_reg & ~clear_mask) | edge_hit;
    end

    // Read mux ignores chipselect; unused upper bits and address 1 read zero.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:    read_mux[WIDTH-1:0] = db;
            ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap_reg;
            default:      read_mux = '0;
        endcase
    end

    // Register state, read data and the interrupt from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_en && (address == ADDR_IRQMASK)) begin
                irqmask_reg <= writedata[WIDTH-1:0];
            end
            edgecap_reg  <= edgecap_next;
            readdata_reg <= read_mux;
            irq_reg      <= |(edgecap_reg & irqmask_reg);
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_lab61soc_btn_pio.sv
// Self-checking bench for lab61soc_btn_pio (WIDTH=4, EDGE_TYPE=rising,
// DEBOUNCE_CYCLES=4). Works with or without PIO_DEBOUNCE_EN; without it the
// effective stability threshold is one cycle.
module tb_lab61soc_btn_pio;

    localparam int W  = 4;
    localparam int DC = 4;
`ifdef PIO_DEBOUNCE_EN
    localparam int D = DC;
`else
    localparam int D = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   readdata;
    logic          irq;

    always #5 clk = ~clk;

    lab61soc_btn_pio #(
        .WIDTH(W),
        .EDGE_TYPE(0),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pipeline of raw samples, history of what the
    // clean stage sees since reset, and the architectural registers.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_mask = '0, m_ecap = '0;
    logic [31:0]  m_rd = '0;
    logic         m_irq = 1'b0;
    logic [W-1:0] hist[$];

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  in_val;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        int          ncyc;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A bit's clean value flips once the sampled level has disagreed with it
    // on each of the last D edges since reset.
    task automatic model_step();
        logic [W-1:0] commit;
        logic [W-1:0] hit;
        logic [W-1:0] clr;
        logic [W-1:0] new_db;
        logic         all_diff;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_mask = '0; m_ecap = '0;
            m_rd = '0; m_irq = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > 40) void'(hist.pop_front());
            commit = '0;
            for (int b = 0; b < W; b++) begin
                if (hist.size() >= D) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (hist[hist.size() - 1 - k][b] == m_db[b]) all_diff = 1'b0;
                    commit[b] = all_diff;
                end
            end
            new_db = m_db ^ commit;
            hit    = commit & new_db;
            case (address)
                2'd0:    m_rd = {28'd0, m_db};
                2'd2:    m_rd = {28'd0, m_mask};
                2'd3:    m_rd = {28'd0, m_ecap};
                default: m_rd = 32'd0;
            endcase
            m_irq = |(m_ecap & m_mask);
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_ecap = (m_ecap & ~clr) | hit;
            m_db = new_db;
            m_s2 = m_s1;
            m_s1 = in_port;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("rd_model", readdata, m_rd);
        check("irq_model", 32'(irq), 32'(m_irq));
    endtask

    task automatic drive(input logic rst, input logic [3:0] in_val, input logic wr,
                         input logic [1:0] addr, input logic [31:0] wd);
        reset      = rst;
        in_port    = in_val;
        chipselect = wr;
        write_n    = ~wr;
        address    = addr;
        writedata  = wd;
    endtask

    initial begin
        int hold;
        logic [3:0] rnd_in;

        vecs.push_back('{"rst",          1'b1, 4'hF, 1'b0, 2'd0, 32'd0,         2,     32'h0, 1'b0});
        vecs.push_back('{"rel_wait",     1'b0, 4'hF, 1'b0, 2'd0, 32'd0,         D + 2, 32'h0, 1'b0});
        vecs.push_back('{"rel_data",     1'b0, 4'hF, 1'b0, 2'd0, 32'd0,         1,     32'hF, 1'b0});
        vecs.push_back('{"ecap_rd",      1'b0, 4'hF, 1'b0, 2'd3, 32'd0,         1,     32'hF, 1'b0});
        vecs.push_back('{"ecap_clr",     1'b0, 4'hF, 1'b1, 2'd3, 32'hF,         1,     32'hF, 1'b0});
        vecs.push_back('{"ecap_chk",     1'b0, 4'hF, 1'b0, 2'd3, 32'd0,         1,     32'h0, 1'b0});
        vecs.push_back('{"fall",         1'b0, 4'h0, 1'b0, 2'd0, 32'd0,         D + 3, 32'h0, 1'b0});
        vecs.push_back('{"fall_ecap",    1'b0, 4'h0, 1'b0, 2'd3, 32'd0,         1,     32'h0, 1'b0});
        vecs.push_back('{"mask_wr",      1'b0, 4'h0, 1'b1, 2'd2, 32'hFFFF_FFF2, 1,     32'h0, 1'b0});
        vecs.push_back('{"mask_rd",      1'b0, 4'h0, 1'b0, 2'd2, 32'd0,         1,     32'h2, 1'b0});
        vecs.push_back('{"press",        1'b0, 4'h2, 1'b0, 2'd0, 32'd0,         D + 2, 32'h0, 1'b0});
        vecs.push_back('{"press_data",   1'b0, 4'h2, 1'b0, 2'd0, 32'd0,         1,     32'h2, 1'b1});
        vecs.push_back('{"irq_clr",      1'b0, 4'h2, 1'b1, 2'd3, 32'h2,         1,     32'h2, 1'b1});
        vecs.push_back('{"irq_off",      1'b0, 4'h2, 1'b0, 2'd3, 32'd0,         1,     32'h0, 1'b0});
        vecs.push_back('{"rel1",         1'b0, 4'h0, 1'b0, 2'd0, 32'd0,         D + 3, 32'h0, 1'b0});
        vecs.push_back('{"press2",       1'b0, 4'h2, 1'b0, 2'd0, 32'd0,         D + 3, 32'h2, 1'b1});
        vecs.push_back('{"mask_off",     1'b0, 4'h2, 1'b1, 2'd2, 32'h0,         1,     32'h2, 1'b1});
        vecs.push_back('{"mask_off_chk", 1'b0, 4'h2, 1'b0, 2'd3, 32'd0,         1,     32'h2, 1'b0});
        vecs.push_back('{"addr1_wr",     1'b0, 4'h2, 1'b1, 2'd1, 32'hFFFF_FFFF, 1,     32'h0, 1'b0});
        vecs.push_back('{"mask_keep",    1'b0, 4'h2, 1'b0, 2'd2, 32'd0,         1,     32'h0, 1'b0});
        vecs.push_back('{"data_rd",      1'b0, 4'h2, 1'b0, 2'd0, 32'd0,         1,     32'h2, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].in_val, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            for (int c = 0; c < vecs[i].ncyc; c++) tick();
            check({vecs[i].name, "_rd"}, readdata, vecs[i].exp_rd);
            check({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
            $display("vec %0d %s rd=%h irq=%b", i, vecs[i].name, readdata, irq);
        end

        // Glitch on bit 0 lasting three cycles: rejected when D > 3.
        drive(1'b0, 4'h2, 1'b1, 2'd3, 32'hF);
        tick();
        drive(1'b0, 4'h3, 1'b0, 2'd0, 32'd0);
        repeat (3) tick();
        drive(1'b0, 4'h2, 1'b0, 2'd0, 32'd0);
        repeat (D + 4) tick();
        check("glitch_data", readdata, 32'h2);
        drive(1'b0, 4'h2, 1'b0, 2'd3, 32'd0);
        tick();
        check("glitch_ecap", readdata, (D <= 3) ? 32'h1 : 32'h0);
        $display("glitch ecap=%h", readdata);

        // Clear of EDGECAP[2] on the very edge bit 2 commits a rise: set wins.
        drive(1'b0, 4'h2, 1'b1, 2'd3, 32'hF);
        tick();
        drive(1'b0, 4'h6, 1'b0, 2'd0, 32'd0);
        repeat (D + 1) tick();
        drive(1'b0, 4'h6, 1'b1, 2'd3, 32'h4);
        tick();
        drive(1'b0, 4'h6, 1'b0, 2'd3, 32'd0);
        tick();
        check("collision_ecap", readdata, 32'h4);
        $display("collision ecap=%h", readdata);
        drive(1'b0, 4'h6, 1'b1, 2'd3, 32'h4);
        tick();
        drive(1'b0, 4'h6, 1'b0, 2'd3, 32'd0);
        tick();
        check("collision_clr", readdata, 32'h0);
        $display("collision clear ecap=%h", readdata);

        // Randomised traffic against the model.
        hold = 0;
        rnd_in = 4'h6;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                rnd_in = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 2 * D + 2);
            end
            hold--;
            reset      = ($urandom_range(0, 149) == 0);
            in_port    = rnd_in;
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            tick();
        end
        $display("random phase done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
